// File: rtl/line_burst_adapter.sv
// line_burst_adapter: cache line fill/writeback to N-beat memory burst bridge; BURST_TIMEOUT_EN adds an idle-beat watchdog with sticky err_o
module line_burst_adapter #(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256,
  parameter int BEAT_W   = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_addr_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [S_LINE-1:0] line_wdata_i,
  output logic [S_LINE-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i,
  output logic              err_o
);
  localparam int N  = S_LINE / BEAT_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {
    IDLE, RD_BURST, WR_BURST, DONE
`ifdef BURST_TIMEOUT_EN
    , ERR
`endif
  } state_t;
  state_t            state;
  logic [CW-1:0]     cnt, nxt;
  logic [S_LINE-1:0] wline;
  logic              last;
  assign last = cnt == CW'(N - 1);
  assign nxt  = last ? '0 : cnt + 1'b1;
`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle;
  logic          expired;
  assign expired = idle == TW'(TIMEOUT - 1);
`else
  assign err_o = 1'b0;
`endif
  // burst sequencer: accepts a line request in IDLE, moves N beats, pulses line_resp_o in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wline        <= '0;
      line_rdata_o <= '0;
      line_resp_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_wdata_o  <= '0;
`ifdef BURST_TIMEOUT_EN
      idle         <= '0;
      err_o        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (line_write_i || line_read_i) begin
            state       <= line_write_i ? WR_BURST : RD_BURST;
            mem_addr_o  <= line_addr_i & ~((32'd1 << S_OFFSET) - 32'd1);
            wline       <= line_wdata_i;
            mem_wdata_o <= line_wdata_i[BEAT_W-1:0];
            mem_write_o <= line_write_i;
            mem_read_o  <= !line_write_i;
`ifdef BURST_TIMEOUT_EN
            idle        <= '0;
`endif
          end
        end
        RD_BURST, WR_BURST: begin
          if (mem_resp_i) begin
            cnt         <= nxt;
            mem_wdata_o <= wline[nxt*BEAT_W +: BEAT_W];
            if (state == RD_BURST) line_rdata_o[cnt*BEAT_W +: BEAT_W] <= mem_rdata_i;
            if (last) begin
              state       <= DONE;
              mem_read_o  <= 1'b0;
              mem_write_o <= 1'b0;
              line_resp_o <= 1'b1;
            end
`ifdef BURST_TIMEOUT_EN
            idle <= '0;
          end else if (expired) begin
            state       <= ERR;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            err_o       <= 1'b1;
          end else begin
            idle <= idle + 1'b1;
`endif
          end
        end
        DONE: begin
          state       <= IDLE;
          line_resp_o <= 1'b0;
        end
`ifdef BURST_TIMEOUT_EN
        ERR: state <= ERR;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_burst_adapter.sv
// tb_line_burst_adapter: randomized bench with a transaction-level model of line_burst_adapter
module tb_line_burst_adapter;
  localparam int SL = 256;
  localparam int BW = 64;
  localparam int N  = SL / BW;
  localparam int TO = 8;
  logic          clk = 0;
  logic          rst = 0;
  logic [31:0]   line_addr_i = 0;
  logic          line_read_i = 0, line_write_i = 0;
  logic [SL-1:0] line_wdata_i = 0;
  logic [SL-1:0] line_rdata_o;
  logic          line_resp_o;
  logic [31:0]   mem_addr_o;
  logic          mem_read_o, mem_write_o;
  logic [BW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_rdata_i = 0;
  logic          mem_resp_i = 0;
  logic          err_o;
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  line_burst_adapter #(.S_OFFSET(5), .S_LINE(SL), .BEAT_W(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .line_addr_i(line_addr_i), .line_read_i(line_read_i),
    .line_write_i(line_write_i), .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o),
    .line_resp_o(line_resp_o), .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_resp_i(mem_resp_i), .err_o(err_o));
  task automatic chk(input string n, input logic [SL-1:0] a, input logic [SL-1:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  // reference model: one transaction in flight, beats counted down, line assembled by shifting
  logic          m_busy, m_wr, m_dead;
  int            m_left, m_idle;
  logic [SL-1:0] m_asm, m_wq;
  logic          e_rd, e_wr, e_resp, e_err;
  logic [31:0]   e_addr;
  logic [BW-1:0] e_wbeat;
  logic [SL-1:0] e_line;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_wr <= 0; m_dead <= 0; m_left <= 0; m_idle <= 0; m_asm <= 0; m_wq <= 0;
      e_rd <= 0; e_wr <= 0; e_resp <= 0; e_err <= 0; e_addr <= 0; e_wbeat <= 0; e_line <= 0;
    end else if (m_dead) begin
    end else if (e_resp) begin
      e_resp <= 0;
    end else if (!m_busy) begin
      if (line_read_i || line_write_i) begin
        m_busy <= 1; m_wr <= line_write_i; m_left <= N; m_idle <= 0; m_wq <= line_wdata_i;
        e_addr <= {line_addr_i[31:5], 5'b0};
        e_wbeat <= line_wdata_i[BW-1:0];
        e_rd <= !line_write_i; e_wr <= line_write_i;
      end
    end else if (mem_resp_i) begin
      m_idle <= 0;
      m_left <= m_left - 1;
      m_wq <= m_wq >> BW;
      e_wbeat <= BW'(m_wq >> BW);
      m_asm <= {mem_rdata_i, m_asm[SL-1:BW]};
      if (m_left == 1) begin
        m_busy <= 0; e_rd <= 0; e_wr <= 0; e_resp <= 1;
        if (!m_wr) e_line <= {mem_rdata_i, m_asm[SL-1:BW]};
      end
    end else begin
`ifdef BURST_TIMEOUT_EN
      m_idle <= m_idle + 1;
      if (m_idle + 1 == TO) begin
        m_busy <= 0; m_dead <= 1; e_rd <= 0; e_wr <= 0; e_err <= 1;
      end
`endif
    end
  end
  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("mem_read", mem_read_o, e_rd);
    chk("mem_write", mem_write_o, e_wr);
    chk("line_resp", line_resp_o, e_resp);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("err", err_o, e_err);
    if (e_wr) chk("mem_wdata", mem_wdata_o, e_wbeat);
    if (!(m_busy && !m_wr) && !m_dead) chk("line_rdata", line_rdata_o, e_line);
  end
  int            c, npulse, resp_at;
  logic          saw_rd;
  int            gap [N];
  logic [BW-1:0] beat [N];
  logic [BW-1:0] wseen [N];
  task automatic step();
    @(negedge clk);
    c++;
    if (line_resp_o) begin npulse++; resp_at = c; end
    if (mem_read_o) saw_rd = 1;
  endtask
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [SL-1:0] wd);
    @(negedge clk);
    line_read_i = rd; line_write_i = wr; line_addr_i = a; line_wdata_i = wd; mem_resp_i = 0;
    c = 1; npulse = 0; resp_at = 0; saw_rd = 0;
    step();
    line_read_i = 0; line_write_i = 0;
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < gap[b]; k++) begin
        mem_resp_i = 0; line_addr_i = $urandom;
        if (rd || wr) begin line_read_i = 1'($urandom); line_write_i = 1'($urandom); end
        step();
      end
      mem_resp_i = 1; mem_rdata_i = beat[b]; wseen[b] = mem_wdata_o;
      step();
    end
    line_read_i = 0; line_write_i = 0;
    repeat (3) begin mem_resp_i = 1'($urandom); mem_rdata_i = {$urandom, $urandom}; step(); end
    mem_resp_i = 0;
  endtask
  initial begin
    logic [SL-1:0] wd;
    repeat (2) @(negedge clk);
    chk("reset line_rdata", line_rdata_o, 0);
    chk("reset mem_addr", mem_addr_o, 0);
    chk("reset mem_wdata", mem_wdata_o, 0);
    chk("reset line_resp", line_resp_o, 0);
    rst = 1;
    repeat (3) begin mem_resp_i = 1; mem_rdata_i = {$urandom, $urandom}; @(negedge clk); end
    mem_resp_i = 0;
    chk("idle spurious rdata", line_rdata_o, 0);
    for (int b = 0; b < N; b++) begin gap[b] = 0; beat[b] = {32'hA0A0_0000, 32'(b)}; end
    xfer(1, 0, 32'h0000_1234, 0);
    chk("fill resp cycle", resp_at, 6);
    chk("fill pulses", npulse, 1);
    chk("fill line", line_rdata_o, {beat[3], beat[2], beat[1], beat[0]});
    chk("fill addr", mem_addr_o, 32'h0000_1220);
    wd = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    gap[1] = 2; gap[2] = 2; gap[3] = 2;
    xfer(0, 1, 32'h0000_8040, wd);
    chk("wb resp cycle", resp_at, 12);
    chk("wb pulses", npulse, 1);
    chk("wb beat0", wseen[0], 64'h8796A5B4C3D2E1F0);
    chk("wb beat2", wseen[2], 64'hFEDCBA9876543210);
    chk("wb beat3", wseen[3], 64'h0123456789ABCDEF);
    chk("wb keeps fill line", line_rdata_o, {beat[3], beat[2], beat[1], beat[0]});
    gap[1] = 1; gap[2] = 0; gap[3] = 1;
    xfer(1, 1, 32'h0000_0FFF, ~wd);
    chk("both high no read", saw_rd, 0);
    chk("both high addr", mem_addr_o, 32'h0000_0FE0);
    @(negedge clk);
    line_read_i = 1; line_addr_i = 32'h4000_0040;
    @(negedge clk);
    line_read_i = 0; mem_resp_i = 1; mem_rdata_i = 64'h1111;
    @(negedge clk);
    mem_rdata_i = 64'h2222;
    @(negedge clk);
    mem_resp_i = 0; rst = 0;
    #1;
    chk("rst mem_read", mem_read_o, 0);
    chk("rst line_rdata", line_rdata_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    @(negedge clk);
    rst = 1;
    for (int b = 0; b < N; b++) begin gap[b] = 0; beat[b] = {32'h5EED_0000, 32'(b + 7)}; end
    xfer(1, 0, 32'h0000_2000, 0);
    chk("post-rst line", line_rdata_o, {beat[3], beat[2], beat[1], beat[0]});
    chk("post-rst pulses", npulse, 1);
    for (int i = 0; i < 60; i++) begin
      logic rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      for (int b = 0; b < N; b++) begin gap[b] = $urandom_range(0, 2); beat[b] = {$urandom, $urandom}; end
      xfer(rd, wr, $urandom, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      chk("rand pulses", npulse, (rd || wr) ? 1 : 0);
    end
`ifdef BURST_TIMEOUT_EN
    begin
      int n;
      @(negedge clk);
      line_read_i = 1; line_addr_i = 32'h0000_3000;
      @(negedge clk);
      line_read_i = 0; n = 0;
      repeat (12) begin if (mem_read_o) n++; @(negedge clk); end
      chk("timeout read cycles", n, TO);
      chk("timeout err", err_o, 1);
      line_write_i = 1;
      repeat (3) @(negedge clk);
      line_write_i = 0;
      chk("err sticky", err_o, 1);
      chk("err no write", mem_write_o, 0);
      rst = 0;
      #1;
      chk("err cleared", err_o, 0);
      @(negedge clk);
      rst = 1;
    end
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
